// File: rtl/inbuf_pingpong_cntl.sv
// inbuf_pingpong_cntl
// Fetches a programmed run of lines from the input-buffer memory into two
// ping-pong line registers and presents each line to the encoder engine for
// M uses. While the engine works on the active bank, the next line is
// prefetched into the idle bank, so back-to-back lines show no bubble as
// long as memory keeps up.
module inbuf_pingpong_cntl #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 10,
  parameter int M_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eng_rst,
  input  logic              cfg_start,
  input  logic [M_W-1:0]    cfg_m,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_num_lines,
  input  logic              eng_data_used,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_data_val,
  output logic [DATA_W-1:0] eng_dout,
  output logic              eng_dout_val,
  output logic              eng_line_last,
  output logic              busy,
  output logic              done,
  output logic              err_underflow
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Either reset source returns the block to its power-on state.
  logic soft_rst;
  assign soft_rst = rst | eng_rst;

  // Control state
  state_t            state_reg;
  logic [M_W-1:0]    m_reg;
  logic [M_W-1:0]    use_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] lines_left_rd_reg;
  logic [ADDR_W-1:0] lines_left_use_reg;
  logic              outstanding_reg;
  logic              active_reg;
  logic              done_reg;
  logic              err_reg;

  // Ping-pong banks
  logic [1:0]        bank_valid_reg;
  logic [DATA_W-1:0] bank_data_reg [2];

  // Decoded per-cycle events
  logic run;
  logic active_valid;
  logic all_banks_valid;
  logic rd_fire;
  logic capture;
  logic fill_sel;
  logic line_last;
  logic consume;
  logic release_line;
  logic [M_W-1:0] m_last;

  // Decode fetch, capture and consume events from the registered state.
  always_comb begin
    run             = (state_reg == RUN);
    active_valid    = bank_valid_reg[active_reg];
    all_banks_valid = &bank_valid_reg;
    // Only one read in flight, and only when a bank can accept it.
    rd_fire         = run && (lines_left_rd_reg != '0) && !outstanding_reg
                      && !all_banks_valid;
    // Data without a pending request (stale or spurious) is discarded.
    capture         = mem_rd_data_val && outstanding_reg;
    // Refill the active bank if it is empty, otherwise prefetch into the other.
    fill_sel        = active_valid ? ~active_reg : active_reg;
    m_last          = m_reg - 1'b1;
    line_last       = active_valid && (use_cnt_reg == m_last);
    consume         = eng_data_used && active_valid;
    release_line    = consume && line_last;
  end

  // Per-bank storage: a capture fills the bank, a final use empties it.
  // A capture and a release never target the same bank in one cycle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      always_ff @(posedge clk) begin
        if (soft_rst) begin
          bank_valid_reg[gi] <= 1'b0;
          bank_data_reg[gi]  <= '0;
        end else if (capture && (fill_sel == 1'(gi))) begin
          bank_valid_reg[gi] <= 1'b1;
          bank_data_reg[gi]  <= mem_rd_data;
        end else if (release_line && (active_reg == 1'(gi))) begin
          bank_valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Run control FSM: start/latch, address generation, use counting, done.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_reg          <= IDLE;
      m_reg              <= '0;
      use_cnt_reg        <= '0;
      addr_reg           <= '0;
      lines_left_rd_reg  <= '0;
      lines_left_use_reg <= '0;
      outstanding_reg    <= 1'b0;
      active_reg         <= 1'b0;
      done_reg           <= 1'b0;
      err_reg            <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      // Engine asked for data that is not there; remembered until reset.
      if (eng_data_used && !active_valid) begin
        err_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (cfg_start) begin
            if (cfg_num_lines != '0) begin
              state_reg          <= RUN;
              m_reg              <= (cfg_m == '0) ? M_W'(1) : cfg_m;
              addr_reg           <= cfg_base_addr;
              lines_left_rd_reg  <= cfg_num_lines;
              lines_left_use_reg <= cfg_num_lines;
              use_cnt_reg        <= '0;
            end else begin
              // Empty run completes immediately.
              done_reg <= 1'b1;
            end
          end
        end

        RUN: begin
          // cfg_start is ignored here: the run in progress owns the config.
          if (rd_fire) begin
            addr_reg          <= addr_reg + 1'b1;
            lines_left_rd_reg <= lines_left_rd_reg - 1'b1;
            outstanding_reg   <= 1'b1;
          end
          if (capture) begin
            outstanding_reg <= 1'b0;
          end
          if (consume) begin
            if (release_line) begin
              use_cnt_reg        <= '0;
              active_reg         <= ~active_reg;
              lines_left_use_reg <= lines_left_use_reg - 1'b1;
              if (lines_left_use_reg == ADDR_W'(1)) begin
                done_reg  <= 1'b1;
                state_reg <= IDLE;
              end
            end else begin
              use_cnt_reg <= use_cnt_reg + 1'b1;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // Output mapping; everything is decoded from registered state.
  always_comb begin
    mem_rd_req    = rd_fire;
    mem_rd_addr   = addr_reg;
    eng_dout      = bank_data_reg[active_reg];
    eng_dout_val  = active_valid;
    eng_line_last = line_last;
    busy          = run;
    done          = done_reg;
    err_underflow = err_reg;
  end

endmodule

// File: tb/tb_inbuf_pingpong_cntl.sv
// Directed bench for inbuf_pingpong_cntl. Each cycle: inputs are set and the
// registered outputs are checked 1 ns after the rising edge, then the clock
// advances. Memory responses are driven by hand at known latencies.
module tb_inbuf_pingpong_cntl;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 10;
  localparam int M_W    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              eng_rst;
  logic              cfg_start;
  logic [M_W-1:0]    cfg_m;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [ADDR_W-1:0] cfg_num_lines;
  logic              eng_data_used;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_data_val;
  logic [DATA_W-1:0] eng_dout;
  logic              eng_dout_val;
  logic              eng_line_last;
  logic              busy;
  logic              done;
  logic              err_underflow;

  int checks = 0;
  int errors = 0;

  localparam logic [DATA_W-1:0] D0  = {8{32'hD0D0_0000}};
  localparam logic [DATA_W-1:0] D1  = {8{32'hD1D1_1111}};
  localparam logic [DATA_W-1:0] E0  = {8{32'hE000_0E00}};
  localparam logic [DATA_W-1:0] E1  = {8{32'hE111_0E11}};
  localparam logic [DATA_W-1:0] E2  = {8{32'hE222_0E22}};
  localparam logic [DATA_W-1:0] E3  = {8{32'hE333_0E33}};
  localparam logic [DATA_W-1:0] F0  = {8{32'hF0F0_00F0}};
  localparam logic [DATA_W-1:0] F1  = {8{32'hF1F1_11F1}};
  localparam logic [DATA_W-1:0] F2  = {8{32'hF2F2_22F2}};
  localparam logic [DATA_W-1:0] G0  = {8{32'h6060_0606}};
  localparam logic [DATA_W-1:0] BAD = {8{32'hBAD0_BAD0}};
  localparam logic [DATA_W-1:0] H0  = {8{32'h4800_0048}};
  localparam logic [DATA_W-1:0] H1  = {8{32'h4811_1148}};
  localparam logic [DATA_W-1:0] K0  = {8{32'h4B00_004B}};
  localparam logic [DATA_W-1:0] K1  = {8{32'h4B11_114B}};

  inbuf_pingpong_cntl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .M_W   (M_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .eng_rst        (eng_rst),
    .cfg_start      (cfg_start),
    .cfg_m          (cfg_m),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_num_lines  (cfg_num_lines),
    .eng_data_used  (eng_data_used),
    .mem_rd_req     (mem_rd_req),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_data    (mem_rd_data),
    .mem_rd_data_val(mem_rd_data_val),
    .eng_dout       (eng_dout),
    .eng_dout_val   (eng_dout_val),
    .eng_line_last  (eng_line_last),
    .busy           (busy),
    .done           (done),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Default per-cycle inputs: no start, no use, no memory response.
  task automatic clr();
    cfg_start       = 1'b0;
    eng_data_used   = 1'b0;
    mem_rd_data_val = 1'b0;
    mem_rd_data     = '0;
  endtask

  task automatic start(input logic [M_W-1:0] m, input logic [ADDR_W-1:0] base,
                       input logic [ADDR_W-1:0] lines);
    cfg_start     = 1'b1;
    cfg_m         = m;
    cfg_base_addr = base;
    cfg_num_lines = lines;
  endtask

  task automatic mem(input logic [DATA_W-1:0] d);
    mem_rd_data_val = 1'b1;
    mem_rd_data     = d;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("[%0t] check %s = %0h", $time, tag, obs);
    end else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    eng_rst = 1'b0;
    cfg_m = '0;
    cfg_base_addr = '0;
    cfg_num_lines = '0;
    clr();
    repeat (3) tick();
    rst = 1'b0;

    // ---------------- reset state ----------------
    chk("rst_req", mem_rd_req, 0);
    chk("rst_addr", mem_rd_addr, 0);
    chk("rst_dout", eng_dout, 0);
    chk("rst_val", eng_dout_val, 0);
    chk("rst_last", eng_line_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_underflow, 0);

    // ---------------- basic run: M=3, base 0x010, 2 lines, latency 2 ----
    clr(); start(3, 10'h010, 2); chk("b0_busy", busy, 0); tick();
    clr(); chk("b1_busy", busy, 1); chk("b1_req", mem_rd_req, 1);
    chk("b1_addr", mem_rd_addr, 10'h010); tick();
    clr(); chk("b2_req", mem_rd_req, 0); tick();
    clr(); mem(D0); chk("b3_val", eng_dout_val, 0); tick();
    clr(); eng_data_used = 1;
    chk("b4_val", eng_dout_val, 1); chk("b4_dout", eng_dout, D0);
    chk("b4_last", eng_line_last, 0); chk("b4_req", mem_rd_req, 1);
    chk("b4_addr", mem_rd_addr, 10'h011); tick();
    clr(); eng_data_used = 1;
    chk("b5_dout", eng_dout, D0); chk("b5_last", eng_line_last, 0);
    chk("b5_req", mem_rd_req, 0); tick();
    clr(); eng_data_used = 1; mem(D1);
    chk("b6_dout", eng_dout, D0); chk("b6_last", eng_line_last, 1); tick();
    clr(); eng_data_used = 1;
    chk("b7_val", eng_dout_val, 1); chk("b7_dout", eng_dout, D1);
    chk("b7_last", eng_line_last, 0); chk("b7_req", mem_rd_req, 0); tick();
    clr(); eng_data_used = 1; chk("b8_last", eng_line_last, 0); tick();
    clr(); eng_data_used = 1; chk("b9_last", eng_line_last, 1);
    chk("b9_done", done, 0); tick();
    clr(); chk("b10_done", done, 1); chk("b10_busy", busy, 0);
    chk("b10_val", eng_dout_val, 0); tick();
    clr(); chk("b11_done", done, 0); chk("b11_err", err_underflow, 0);

    // ---------------- M=0, 4 lines, latency 1, base 0x020 ----------------
    clr(); start(0, 10'h020, 4); tick();
    clr(); chk("m0_c1_req", mem_rd_req, 1); chk("m0_c1_addr", mem_rd_addr, 10'h020); tick();
    clr(); mem(E0); chk("m0_c2_req", mem_rd_req, 0); tick();
    clr(); eng_data_used = 1;
    chk("m0_c3_dout", eng_dout, E0); chk("m0_c3_last", eng_line_last, 1);
    chk("m0_c3_req", mem_rd_req, 1); chk("m0_c3_addr", mem_rd_addr, 10'h021); tick();
    clr(); mem(E1); chk("m0_c4_val", eng_dout_val, 0); tick();
    clr(); eng_data_used = 1;
    chk("m0_c5_dout", eng_dout, E1); chk("m0_c5_last", eng_line_last, 1);
    chk("m0_c5_req", mem_rd_req, 1); chk("m0_c5_addr", mem_rd_addr, 10'h022); tick();
    clr(); mem(E2); chk("m0_c6_val", eng_dout_val, 0); tick();
    clr(); eng_data_used = 1;
    chk("m0_c7_dout", eng_dout, E2); chk("m0_c7_last", eng_line_last, 1);
    chk("m0_c7_req", mem_rd_req, 1); chk("m0_c7_addr", mem_rd_addr, 10'h023); tick();
    clr(); mem(E3); chk("m0_c8_val", eng_dout_val, 0); tick();
    clr(); eng_data_used = 1;
    chk("m0_c9_dout", eng_dout, E3); chk("m0_c9_last", eng_line_last, 1);
    chk("m0_c9_req", mem_rd_req, 0); chk("m0_c9_done", done, 0); tick();
    clr(); chk("m0_c10_done", done, 1); chk("m0_c10_busy", busy, 0); tick();

    // ---------------- M=1, 1 line, base 0x030 ----------------
    clr(); start(1, 10'h030, 1); tick();
    clr(); chk("m1_req", mem_rd_req, 1); chk("m1_addr", mem_rd_addr, 10'h030); tick();
    clr(); mem(E1); tick();
    clr(); eng_data_used = 1; chk("m1_dout", eng_dout, E1);
    chk("m1_last", eng_line_last, 1); tick();
    clr(); chk("m1_done", done, 1); chk("m1_busy", busy, 0); tick();

    // ---------------- backpressure: M=2, 3 lines, base 0x040 ----------------
    clr(); start(2, 10'h040, 3); tick();
    clr(); chk("bp1_req", mem_rd_req, 1); chk("bp1_addr", mem_rd_addr, 10'h040); tick();
    clr(); mem(F0); tick();
    clr(); chk("bp3_dout", eng_dout, F0); chk("bp3_req", mem_rd_req, 1);
    chk("bp3_addr", mem_rd_addr, 10'h041); tick();
    clr(); mem(F1); chk("bp4_req", mem_rd_req, 0); tick();
    for (int i = 0; i < 10; i++) begin
      clr(); chk($sformatf("bp_idle%0d_req", i), mem_rd_req, 0);
      chk($sformatf("bp_idle%0d_dout", i), eng_dout, F0); tick();
    end
    clr(); eng_data_used = 1; chk("bp15_last", eng_line_last, 0);
    chk("bp15_req", mem_rd_req, 0); tick();
    clr(); eng_data_used = 1; chk("bp16_last", eng_line_last, 1);
    chk("bp16_req", mem_rd_req, 0); tick();
    clr(); eng_data_used = 1; chk("bp17_val", eng_dout_val, 1);
    chk("bp17_dout", eng_dout, F1); chk("bp17_req", mem_rd_req, 1);
    chk("bp17_addr", mem_rd_addr, 10'h042); tick();
    clr(); eng_data_used = 1; mem(F2); chk("bp18_last", eng_line_last, 1); tick();
    clr(); eng_data_used = 1; chk("bp19_dout", eng_dout, F2);
    chk("bp19_last", eng_line_last, 0); tick();
    clr(); eng_data_used = 1; chk("bp20_last", eng_line_last, 1); tick();
    clr(); chk("bp21_done", done, 1); chk("bp21_err", err_underflow, 0); tick();

    // ---------------- underflow and spurious data: M=2, 1 line, base 0x050 ----
    clr(); start(2, 10'h050, 1); tick();
    clr(); eng_data_used = 1; chk("uf1_val", eng_dout_val, 0); tick();
    clr(); chk("uf2_err", err_underflow, 1); chk("uf2_busy", busy, 1); mem(G0); tick();
    clr(); chk("uf3_dout", eng_dout, G0); chk("uf3_last", eng_line_last, 0);
    chk("uf3_req", mem_rd_req, 0); mem(BAD); tick();
    clr(); eng_data_used = 1; chk("uf4_dout", eng_dout, G0);
    chk("uf4_last", eng_line_last, 0); tick();
    clr(); eng_data_used = 1; chk("uf5_last", eng_line_last, 1); tick();
    clr(); chk("uf6_done", done, 1); chk("uf6_err", err_underflow, 1); mem(BAD); tick();
    clr(); chk("uf7_val", eng_dout_val, 0); chk("uf7_err", err_underflow, 1); tick();

    // ---------------- mid-run engine reset: M=1, 2 lines, base 0x060 ----
    clr(); start(1, 10'h060, 2); tick();
    clr(); chk("mr1_req", mem_rd_req, 1); tick();
    clr(); eng_rst = 1; tick();
    clr(); eng_rst = 0;
    chk("mr_req", mem_rd_req, 0); chk("mr_addr", mem_rd_addr, 0);
    chk("mr_dout", eng_dout, 0); chk("mr_val", eng_dout_val, 0);
    chk("mr_last", eng_line_last, 0); chk("mr_busy", busy, 0);
    chk("mr_done", done, 0); chk("mr_err", err_underflow, 0);
    mem(H0); tick();
    clr(); chk("mr_late_val", eng_dout_val, 0); chk("mr_late_dout", eng_dout, 0);
    start(1, 10'h070, 1); tick();
    clr(); chk("mr_new_req", mem_rd_req, 1); chk("mr_new_addr", mem_rd_addr, 10'h070); tick();
    clr(); mem(H1); tick();
    clr(); eng_data_used = 1; chk("mr_new_dout", eng_dout, H1);
    chk("mr_new_last", eng_line_last, 1); tick();
    clr(); chk("mr_new_done", done, 1); tick();

    // ---------------- address wrap + start while busy ----------------
    clr(); start(1, 10'h3FF, 2); tick();
    clr(); chk("wr1_addr", mem_rd_addr, 10'h3FF); chk("wr1_req", mem_rd_req, 1); tick();
    clr(); mem(K0); tick();
    clr(); eng_data_used = 1; chk("wr3_dout", eng_dout, K0);
    chk("wr3_req", mem_rd_req, 1); chk("wr3_addr", mem_rd_addr, 10'h000); tick();
    clr(); mem(K1); start(5, 10'h100, 5); tick();
    clr(); eng_data_used = 1; chk("wr5_dout", eng_dout, K1); chk("wr5_busy", busy, 1);
    chk("wr5_req", mem_rd_req, 0); tick();
    clr(); chk("wr6_done", done, 1); chk("wr6_busy", busy, 0); chk("wr6_req", mem_rd_req, 0); tick();
    clr(); chk("wr7_busy", busy, 0); tick();

    // ---------------- empty run ----------------
    clr(); start(2, 10'h123, 0); tick();
    clr(); chk("e1_done", done, 1); chk("e1_busy", busy, 0); chk("e1_req", mem_rd_req, 0); tick();
    clr(); chk("e2_done", done, 0); chk("e2_req", mem_rd_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inbuf_pingpong_cntl.md
Name: inbuf_pingpong_cntl

Overview:
- Next-generation input-buffer controller for the EC encoder engine.
- Fetches a programmed run of data lines from the input-buffer memory into two ping-pong line registers.
- Presents each line to the engine for exactly M uses, prefetching the next line into the idle bank so the engine never stalls when memory keeps up.
- Adds what the previous controller lacks: address generation, line count, run start/done, double buffering, configurable widths and underflow reporting.

Parameters:
- DATA_W, 256, width of one memory line and of the engine data output.
- ADDR_W, 10, input-buffer memory address width; also the width of the line counters.
- M_W, 4, width of the reuse count M (max M = 2^M_W-1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- eng_rst  in  1  synchronous active-high engine soft reset; same effect as rst
- cfg_start  in  1  one-cycle pulse; samples cfg_* and starts a run
- cfg_m  in  M_W  uses per line; 0 treated as 1
- cfg_base_addr  in  ADDR_W  address of first line
- cfg_num_lines  in  ADDR_W  lines in the run; 0 = empty run
- eng_data_used  in  1  engine consumed the presented line once
- mem_rd_req  out  1  read request, one cycle per line
- mem_rd_addr  out  ADDR_W  read address, valid with mem_rd_req
- mem_rd_data  in  DATA_W  read data
- mem_rd_data_val  in  1  read data valid, any latency ≥1 cycle after req
- eng_dout  out  DATA_W  active bank contents
- eng_dout_val  out  1  active bank holds a valid line
- eng_line_last  out  1  current use is the M-th use of the line
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, last use of last line accepted
- err_underflow  out  1  sticky; eng_data_used seen while eng_dout_val=0

Behaviour:
- Reset (rst or eng_rst, either in any cycle, including mid-run): state IDLE; both banks invalid and cleared to 0; counters 0; active pointer = bank 0. Outputs: mem_rd_req=0, mem_rd_addr=0, eng_dout=0, eng_dout_val=0, eng_line_last=0, busy=0, done=0, err_underflow=0. In-flight read data arriving after reset is dropped.
- States: IDLE, RUN.
  - IDLE to RUN: on cfg_start with cfg_num_lines≠0.
  - cfg_start with cfg_num_lines=0: stay IDLE, pulse done the next cycle.
  - cfg_start while busy: ignored.
- On start, latch m_r = max(cfg_m, 1), addr_r = cfg_base_addr, lines_left_rd = lines_left_use = cfg_num_lines.
- busy = (state==RUN).
- Fetch rule, evaluated in RUN:
  - mem_rd_req=1 when lines_left_rd≠0, no read is outstanding, and at least one bank is invalid.
  - At most one outstanding read.
  - mem_rd_addr=addr_r.
  - On req: addr_r+1 (wraps modulo 2^ADDR_W), lines_left_rd−1, outstanding=1.
- Capture:
  - mem_rd_data_val with outstanding=1 writes mem_rd_data into the fill bank, which is the active bank if the active bank is invalid, otherwise the other bank.
  - That bank becomes valid the next cycle; outstanding clears.
  - mem_rd_data_val with outstanding=0 is ignored.
- Presentation: eng_dout = active bank data; eng_dout_val = active bank valid; eng_line_last = eng_dout_val && use_cnt==m_r−1.
- Consume (eng_data_used && eng_dout_val):
  - If not last use: use_cnt+1.
  - If last use: use_cnt=0, active bank invalidated, active pointer toggles, lines_left_use−1.
  - If lines_left_use was 1: done pulses next cycle, state returns to IDLE.
- The freed bank may be re-requested from the cycle after release. A capture and a release in the same cycle both take effect; the capture targets the non-active bank.
- eng_data_used with eng_dout_val=0: no state change; err_underflow set, cleared only by reset.
- Latency:
  - cfg_start at cycle 0 gives mem_rd_req at cycle 1.
  - mem_rd_data_val at cycle k gives eng_dout_val at cycle k+1.
  - Second req at cycle k+1 (prefetch into bank 1).

Test Plan:
- Basic run: M=3, base=0x010, lines=2, memory latency 2, data D0/D1; engine asserts used every cycle once valid. Required: reqs to 0x010 then 0x011; D0 shown for exactly 3 uses with eng_line_last on the 3rd; D1 valid in the same cycle D0 is released (no bubble); done one cycle after D1's 3rd use; busy falls.
- M=0 and M=1: lines=4, engine always ready. Required: each line used once, eng_line_last permanently 1 while valid, 4 reqs, done after the 4th use.
- Backpressure: M=2, lines=3, engine idle 10 cycles. Required: exactly 2 reqs issued (both banks fill), third req only after line 0 is released; data order preserved.
- Underflow and spurious data: eng_data_used before the first valid, plus a mem_rd_data_val with no outstanding read. Required: err_underflow=1 and sticky; counters unchanged; spurious data not captured.
- Mid-run reset: eng_rst asserted while a read is outstanding, then the data returns. Required: all outputs at reset values next cycle; the returned data is ignored; a new cfg_start then runs cleanly from its own base address.
- Edge cases: base=0x3FF with lines=2 gives addresses 0x3FF then 0x000. lines=0 gives a done pulse with no req. cfg_start while busy is ignored.
